data_mem_responder: RTL and testbench

//  Responder side of the CPU data-memory interface: a word-addressed data RAM plus memory-mapped I/O.

---
 rtl/mem_map_pkg.sv | 42 ++++
 rtl/data_mem_responder_sync_fifo.sv | 60 ++++++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map and STATUS word layout of the CPU data-memory responder.
// Shared with the CPU test programs.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] OUT_PUSH_ADDR = 32'hF000_0000;
    localparam logic [31:0] STATUS_ADDR   = 32'hF000_0004;
    localparam logic [31:0] CYCLES_ADDR   = 32'hF000_0008;

    localparam int unsigned ST_ERR_BIT    = 31;
    localparam int unsigned ST_DROP_LSB   = 16;
    localparam int unsigned ST_COUNT_LSB  = 8;
    localparam int unsigned ST_FULL_BIT   = 1;
    localparam int unsigned ST_EMPTY_BIT  = 0;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_RAM,
        ACC_PUSH,
        ACC_STATUS,
        ACC_CYCLES,
        ACC_BAD
    } acc_t;

    function automatic logic [31:0] pack_status(
        input logic       err,
        input logic [7:0] drop_cnt,
        input logic [7:0] count,
        input logic       full,
        input logic       empty
    );
        logic [31:0] v_word;
        v_word                     = '0;
        v_word[ST_ERR_BIT]         = err;
        v_word[ST_DROP_LSB +: 8]   = drop_cnt;
        v_word[ST_COUNT_LSB +: 8]  = count;
        v_word[ST_FULL_BIT]        = full;
        v_word[ST_EMPTY_BIT]       = empty;
        return v_word;
    endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Synchronous FIFO with registered pointers; head word reads 0 while empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM, pixel-output FIFO, STATUS and CYCLES registers.
// Read data is combinational so the MEM/WB register captures it at the next edge.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_AW     = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   mem_addr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          read_en,
    input  logic          write_en,
    output logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          err
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0]     r_ram [2**RAM_AW];
    logic [31:0]       r_cycles;
    logic              r_err;
    logic [7:0]        r_drop_cnt;

    acc_t              w_acc;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_ram_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_status_wr;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCW-1:0]    w_fifo_count;
    logic [DW-1:0]     w_fifo_head;
    logic [7:0]        w_drop_base;

    assign w_ram_idx = mem_addr[RAM_AW+1:2];
    assign w_ram_hit = (mem_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);

    // Reset suppresses every request, so nothing downstream needs its own rst gating.
    always_comb begin
        w_acc = ACC_NONE;
        if (!rst && (read_en || write_en)) begin
            if ((mem_addr[1:0] != 2'b00) || (read_en && write_en)) begin
                w_acc = ACC_BAD;
            end else if (w_ram_hit) begin
                w_acc = ACC_RAM;
            end else if (mem_addr == OUT_PUSH_ADDR) begin
                w_acc = write_en ? ACC_PUSH : ACC_BAD;
            end else if (mem_addr == STATUS_ADDR) begin
                w_acc = ACC_STATUS;
            end else if (mem_addr == CYCLES_ADDR) begin
                w_acc = read_en ? ACC_CYCLES : ACC_BAD;
            end else begin
                w_acc = ACC_BAD;
            end
        end
    end

    assign w_push      = (w_acc == ACC_PUSH);
    assign w_pop       = out_valid && out_ready;
    assign w_drop      = w_push && w_fifo_full && !w_pop;
    assign w_status_wr = (w_acc == ACC_STATUS) && write_en;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (mem_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_head;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if ((w_acc == ACC_RAM) && write_en) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
    end

    // STATUS write clears first; a drop or error in the same cycle then re-applies.
    assign w_drop_base = w_status_wr ? 8'd0 : r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
            r_cycles   <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if ((w_acc == ACC_BAD) || w_drop) begin
                r_err <= 1'b1;
            end else if (w_status_wr) begin
                r_err <= 1'b0;
            end
            if (w_drop && (w_drop_base != 8'hFF)) begin
                r_drop_cnt <= w_drop_base + 8'd1;
            end else begin
                r_drop_cnt <= w_drop_base;
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (read_en) begin
            case (w_acc)
                ACC_RAM:    mem_rdata = r_ram[w_ram_idx];
                ACC_STATUS: mem_rdata = pack_status(r_err, r_drop_cnt, 8'(w_fifo_count),
                                                    w_fifo_full, w_fifo_empty);
                ACC_CYCLES: mem_rdata = r_cycles;
                default:    mem_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: RAM, error flag, STATUS/CYCLES and the output FIFO.
module tb_data_mem_responder;
    import mem_map_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        read_en;
    logic        write_en;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tb_cyc;

    data_mem_responder #(
        .RAM_AW     (10),
        .FIFO_DEPTH (16),
        .DW         (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .read_en   (read_en),
        .write_en  (write_en),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference free-running counter: value seen by a read after the latest edge.
    always @(posedge clk) begin
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_en   = 1'b0;
        write_en  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        write_en  = 1'b1;
        read_en   = 1'b0;
        if (addr == OUT_PUSH_ADDR && !rst && exp_q.size() < 16) exp_q.push_back(data);
        tick();
        idle();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        read_en  = 1'b1;
        write_en = 1'b0;
        #1;
        check_eq(tag, mem_rdata, exp);
        tick();
        idle();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            #1;
            if (out_valid) check_eq("drain_word", out_data, exp_q.pop_front());
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle();
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) tick();
        mem_addr = 32'h10;
        read_en  = 1'b1;
        #1;
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_odata", out_data, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        tick();
        idle();
        rst = 1'b0;
        rd_chk("cycles_first", CYCLES_ADDR, 32'd0);

        wr(32'h10, 32'hDEAD_BEEF);
        rd_chk("t1_read", 32'h10, 32'hDEAD_BEEF);
        check_eq("t1_err", {31'd0, err}, 32'd0);

        wr(32'h13, 32'h1234_5678);
        check_eq("t2_err_set", {31'd0, err}, 32'd1);
        rd_chk("t2_ram_kept", 32'h10, 32'hDEAD_BEEF);
        wr(STATUS_ADDR, 32'd0);
        check_eq("t2_err_clr", {31'd0, err}, 32'd0);

        wr(32'hFFC, 32'hCAFE_F00D);
        rd_chk("last_word", 32'hFFC, 32'hCAFE_F00D);
        check_eq("last_word_err", {31'd0, err}, 32'd0);
        rd_chk("unmapped_rd", 32'h1000, 32'd0);
        check_eq("unmapped_err", {31'd0, err}, 32'd1);
        wr(STATUS_ADDR, 32'd0);
        rd_chk("push_rd", OUT_PUSH_ADDR, 32'd0);
        check_eq("push_rd_err", {31'd0, err}, 32'd1);
        wr(STATUS_ADDR, 32'd0);
        wr(CYCLES_ADDR, 32'd5);
        check_eq("cyc_wr_err", {31'd0, err}, 32'd1);
        wr(STATUS_ADDR, 32'd0);
        rd_chk("cycles_run", CYCLES_ADDR, tb_cyc);

        for (int i = 1; i <= 17; i++) wr(OUT_PUSH_ADDR, 32'(i));
        rd_chk("t3_status", STATUS_ADDR, 32'h8001_1002);
        check_eq("t3_err", {31'd0, err}, 32'd1);
        drain();
        check_eq("t3_empty_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t3_empty_data", out_data, 32'd0);
        wr(STATUS_ADDR, 32'd0);
        rd_chk("t3_status_clr", STATUS_ADDR, 32'h0000_0001);

        for (int i = 0; i < 16; i++) wr(OUT_PUSH_ADDR, 32'(100 + i));
        out_ready = 1'b1;
        mem_addr  = OUT_PUSH_ADDR;
        mem_wdata = 32'd200;
        write_en  = 1'b1;
        #1;
        check_eq("t4_head", out_data, exp_q.pop_front());
        exp_q.push_back(32'd200);
        tick();
        idle();
        out_ready = 1'b0;
        rd_chk("t4_status", STATUS_ADDR, 32'h0000_1002);
        drain();

        wr(32'h20, 32'h1111_1111);
        mem_addr  = 32'h20;
        mem_wdata = 32'h2222_2222;
        read_en   = 1'b1;
        write_en  = 1'b1;
        #1;
        check_eq("t5_rdata", mem_rdata, 32'd0);
        tick();
        idle();
        check_eq("t5_err", {31'd0, err}, 32'd1);
        wr(STATUS_ADDR, 32'd0);
        rd_chk("t5_ram_kept", 32'h20, 32'h1111_1111);

        wr(32'h40, 32'h0000_AAAA);
        for (int i = 1; i <= 5; i++) wr(OUT_PUSH_ADDR, 32'(i));
        check_eq("t6_queued", {31'd0, out_valid}, 32'd1);
        rst       = 1'b1;
        mem_addr  = 32'h40;
        mem_wdata = 32'h0000_5555;
        write_en  = 1'b1;
        tick();
        tick();
        exp_q.delete();
        check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
        idle();
        rst = 1'b0;
        rd_chk("t6_cycles", CYCLES_ADDR, 32'd0);
        rd_chk("t6_status", STATUS_ADDR, 32'h0000_0001);
        rd_chk("t6_ram_kept", 32'h40, 32'h0000_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
